// File: rtl/bsg_test_dram_rx_tracker_pkg.sv
// Shared types for the DRAM read-response tracker: FSM states, queue entry layout, reset constants.
// The entry field widths match the tracker's default parameters; the top module defaults to these widths.
package bsg_test_dram_rx_tracker_pkg;

  localparam int ch_addr_width_gp = 32;
  localparam int ctr_width_gp     = 32;

  // Slice to the counter width to get the lat_min reset value (no latency seen yet).
  localparam logic [63:0] all_ones_gp = '1;

  typedef enum logic [1:0] {eIdle, eRun, eDrain, eDone} tracker_state_e;

  typedef struct packed {
    logic [ch_addr_width_gp-1:0] addr;
    logic [ctr_width_gp-1:0]     stamp;
  } rx_entry_s;

endpackage

// File: rtl/bsg_test_dram_rx_tracker_queue.sv
// Circular buffer of outstanding reads. Head read is combinational; a push or pop takes effect at the next edge.
// The caller holds off pushes when full_o is high. Pushes while full and pops while empty are ignored.
module bsg_test_dram_rx_tracker_queue #(
  parameter int width_p = 64,
  parameter int els_p   = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int lg_els_lp = $clog2(els_p);

  logic [lg_els_lp:0]  wptr_q, rptr_q;
  logic [width_p-1:0]  mem_q [els_p];
  logic                push_ok, pop_ok;

  // The wrap bits tell full apart from empty when the index bits match.
  assign full_o  = (wptr_q[lg_els_lp] != rptr_q[lg_els_lp]) &&
                   (wptr_q[lg_els_lp-1:0] == rptr_q[lg_els_lp-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[lg_els_lp-1:0]];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (lg_els_lp+1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (lg_els_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[lg_els_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bsg_test_dram_rx_tracker.sv
// Pairs DRAM read beats with queued read requests in order; checks the data and collects latency and bandwidth statistics.
// Outputs are registered and update one cycle after each event. rd_ready_o drops while the queue is full.
module bsg_test_dram_rx_tracker
  import bsg_test_dram_rx_tracker_pkg::*;
#(
  parameter int ch_addr_width_p = ch_addr_width_gp,
  parameter int data_width_p    = 256,
  parameter int els_p           = 16,
  parameter int ctr_width_p     = ctr_width_gp,
  localparam int cnt_width_lp   = $clog2(els_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       req_v_i,
  input  logic                       req_yumi_i,
  input  logic                       req_write_not_read_i,
  input  logic [ch_addr_width_p-1:0] req_ch_addr_i,
  output logic                       rd_ready_o,
  input  logic                       data_v_i,
  input  logic [data_width_p-1:0]    data_i,
  input  logic                       done_i,
  output logic [cnt_width_lp-1:0]    outstanding_o,
  output logic [ctr_width_p-1:0]     reads_o,
  output logic [ctr_width_p-1:0]     writes_o,
  output logic [2*ctr_width_p-1:0]   lat_sum_o,
  output logic [ctr_width_p-1:0]     lat_min_o,
  output logic [ctr_width_p-1:0]     lat_max_o,
  output logic [ctr_width_p-1:0]     run_cycles_o,
  output logic [ctr_width_p-1:0]     mismatch_o,
  output logic                       error_o,
  output logic                       report_v_o
);

  tracker_state_e               state_q;
  rx_entry_s                    push_entry, head_entry;
  logic                         q_full, q_empty;
  logic [ctr_width_p-1:0]       cycle_q, reads_q, writes_q, lat_min_q, lat_max_q, run_q, mismatch_q;
  logic [2*ctr_width_p-1:0]     lat_sum_q;
  logic [cnt_width_lp-1:0]      outstanding_q, outstanding_d;
  logic                         rd_ready_q, error_q, report_q;

  logic                         in_done, req_acc, rd_acc, wr_acc, push, pop;
  logic                         underflow, overflow, late, bad_data;
  logic [ctr_width_p-1:0]       lat;
  logic [data_width_p-1:0]      exp_data;

  always_comb begin
    in_done       = (state_q == eDone);
    req_acc       = req_v_i & req_yumi_i & ~in_done;
    rd_acc        = req_acc & ~req_write_not_read_i;
    wr_acc        = req_acc & req_write_not_read_i;
    // Full is judged on registered state, so a same-cycle pop never frees room.
    push          = rd_acc & ~q_full;
    overflow      = rd_acc & q_full;
    pop           = data_v_i & ~in_done & ~q_empty;
    underflow     = data_v_i & ~in_done & q_empty;
    late          = in_done & ((req_v_i & req_yumi_i) | data_v_i);
    lat           = cycle_q - head_entry.stamp;
    exp_data      = data_width_p'(head_entry.addr);
    bad_data      = pop & (data_i != exp_data);
    outstanding_d = outstanding_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
    push_entry    = '{addr: req_ch_addr_i, stamp: cycle_q};
  end

  bsg_test_dram_rx_tracker_queue #(
    .width_p($bits(rx_entry_s)),
    .els_p  (els_p)
  ) queue (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (push),
    .data_i   (push_entry),
    .pop_i    (pop),
    .head_o   (head_entry),
    .full_o   (q_full),
    .empty_o  (q_empty)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycle_q       <= '0;
      outstanding_q <= '0;
      rd_ready_q    <= 1'b1;
      reads_q       <= '0;
      writes_q      <= '0;
      lat_sum_q     <= '0;
      lat_min_q     <= all_ones_gp[ctr_width_p-1:0];
      lat_max_q     <= '0;
      run_q         <= '0;
      mismatch_q    <= '0;
      error_q       <= 1'b0;
    end else begin
      cycle_q       <= cycle_q + ctr_width_p'(1);
      outstanding_q <= outstanding_d;
      rd_ready_q    <= (outstanding_d < cnt_width_lp'(els_p));
      if (rd_acc) reads_q  <= reads_q + ctr_width_p'(1);
      if (wr_acc) writes_q <= writes_q + ctr_width_p'(1);
      if (pop) begin
        lat_sum_q <= lat_sum_q + (2*ctr_width_p)'(lat);
        if (lat < lat_min_q) lat_min_q <= lat;
        if (lat > lat_max_q) lat_max_q <= lat;
      end
      if (bad_data) mismatch_q <= mismatch_q + ctr_width_p'(1);
      if (state_q == eRun || state_q == eDrain) run_q <= run_q + ctr_width_p'(1);
      error_q <= error_q | underflow | overflow | bad_data | late;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIdle;
      report_q <= 1'b0;
    end else begin
      case (state_q)
        eIdle:  if (req_acc) state_q <= eRun;
        eRun:   if (done_i) state_q <= eDrain;
        eDrain: if (outstanding_q == '0 && !push && !pop) begin
                  state_q  <= eDone;
                  report_q <= 1'b1;
                end
        eDone:  ;
        default: state_q <= eIdle;
      endcase
    end
  end

  assign rd_ready_o    = rd_ready_q;
  assign outstanding_o = outstanding_q;
  assign reads_o       = reads_q;
  assign writes_o      = writes_q;
  assign lat_sum_o     = lat_sum_q;
  assign lat_min_o     = lat_min_q;
  assign lat_max_o     = lat_max_q;
  assign run_cycles_o  = run_q;
  assign mismatch_o    = mismatch_q;
  assign error_o       = error_q;
  assign report_v_o    = report_q;

endmodule
